// File: rtl/writeback_stage_if.sv
// Writeback-stage bundle: W-register inputs, decode read ports, status.
// master drives the W/decode inputs; slave is the writeback stage.
interface writeback_stage_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
);
  logic [2:0]        stat_w;
  logic [3:0]        icode_w;
  logic [3:0]        dstE_w;
  logic [3:0]        dstM_w;
  logic [DATA_W-1:0] valE_w;
  logic [DATA_W-1:0] valM_w;
  logic [3:0]        srcA_d;
  logic [3:0]        srcB_d;
  logic [DATA_W-1:0] rvalA_d;
  logic [DATA_W-1:0] rvalB_d;
  logic [2:0]        prog_stat;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    output stat_w, icode_w, dstE_w, dstM_w,
    output valE_w, valM_w, srcA_d, srcB_d,
    input  rvalA_d, rvalB_d, prog_stat, halted, retired
  );

  modport slave (
    input  stat_w, icode_w, dstE_w, dstM_w,
    input  valE_w, valM_w, srcA_d, srcB_d,
    output rvalA_d, rvalB_d, prog_stat, halted, retired
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 writeback: 15x64 register file, run/halt status, retire counter.
// Optional WB_BYPASS_EN makes the decode read ports write-through.
module writeback_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  wb
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [3:0] RNONE = 4'hF;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [2:0]        r_stat;
  logic [2:0]        w_stat_nxt;
  logic [CNT_W-1:0]  r_retired;
  logic [CNT_W-1:0]  w_retired_nxt;
  logic [DATA_W-1:0] r_rf [15];
  logic              w_commit;
  logic              w_we_e;
  logic              w_we_m;
  logic [DATA_W-1:0] w_rvalA;
  logic [DATA_W-1:0] w_rvalB;
  logic              w_unused;

  assign w_unused = ^wb.icode_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_stat    <= 3'd1;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_stat    <= w_stat_nxt;
      r_retired <= w_retired_nxt;
    end
  end

  // Illegal status codes 5..7 fall into the INS branch.
  always_comb begin
    w_state_nxt   = r_state;
    w_stat_nxt    = r_stat;
    w_retired_nxt = r_retired;
    w_commit      = 1'b0;
    if (r_state == ST_RUN) begin
      case (wb.stat_w)
        3'd0: begin
          w_commit = 1'b0;
        end
        3'd1: begin
          w_commit      = 1'b1;
          w_retired_nxt = r_retired + 1'b1;
        end
        3'd2: begin
          w_retired_nxt = r_retired + 1'b1;
          w_stat_nxt    = 3'd2;
          w_state_nxt   = ST_HALT;
        end
        3'd3: begin
          w_stat_nxt  = 3'd3;
          w_state_nxt = ST_HALT;
        end
        default: begin
          w_stat_nxt  = 3'd4;
          w_state_nxt = ST_HALT;
        end
      endcase
    end
  end

  assign w_we_e = w_commit && (wb.dstE_w != RNONE);
  assign w_we_m = w_commit && (wb.dstM_w != RNONE);

  // valM has priority so popq %rsp leaves the popped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 15; i++) r_rf[i] <= '0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (w_we_m && wb.dstM_w == i[3:0])
          r_rf[i] <= wb.valM_w;
        else if (w_we_e && wb.dstE_w == i[3:0])
          r_rf[i] <= wb.valE_w;
      end
    end
  end

  always_comb begin
    w_rvalA = '0;
    if (wb.srcA_d != RNONE) w_rvalA = r_rf[wb.srcA_d];
`ifdef WB_BYPASS_EN
    if (w_we_m && wb.srcA_d == wb.dstM_w)
      w_rvalA = wb.valM_w;
    else if (w_we_e && wb.srcA_d == wb.dstE_w)
      w_rvalA = wb.valE_w;
`endif
  end

  always_comb begin
    w_rvalB = '0;
    if (wb.srcB_d != RNONE) w_rvalB = r_rf[wb.srcB_d];
`ifdef WB_BYPASS_EN
    if (w_we_m && wb.srcB_d == wb.dstM_w)
      w_rvalB = wb.valM_w;
    else if (w_we_e && wb.srcB_d == wb.dstE_w)
      w_rvalB = wb.valE_w;
`endif
  end

  assign wb.rvalA_d   = w_rvalA;
  assign wb.rvalB_d   = w_rvalB;
  assign wb.prog_stat = r_stat;
  assign wb.halted    = (r_state == ST_HALT);
  assign wb.retired   = r_retired;

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the Y86-64 pipeline; consumes the W-register outputs (stat_w, icode_w, dstE_w, dstM_w, valE_w, valM_w).
- Owns the 15-entry x 64-bit architectural register file:
  - commits valE/valM at the rising edge;
  - serves the two decode-stage read ports.
- Tracks program status with a run/halt state machine and counts retired instructions.

Parameters:
- DATA_W, 64, register and value width
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stat_w  input  3  W-stage status: 0 BUB, 1 AOK, 2 HLT, 3 ADR, 4 INS
- icode_w  input  4  W-stage instruction code
- dstE_w  input  4  destination for valE; 4'hF = RNONE (no write)
- dstM_w  input  4  destination for valM; 4'hF = RNONE
- valE_w  input  DATA_W  execute result
- valM_w  input  DATA_W  memory read result
- srcA_d  input  4  decode read address A; 4'hF = RNONE
- srcB_d  input  4  decode read address B; 4'hF = RNONE
- rvalA_d  output  DATA_W  register value for srcA_d
- rvalB_d  output  DATA_W  register value for srcB_d
- prog_stat  output  3  architectural program status
- halted  output  1  high once the state machine is in HALT
- retired  output  CNT_W  number of instructions retired since reset

Behaviour:
- Reset (async, rst=1): all 15 registers = 0; state = RUN; prog_stat = 1 (AOK); halted = 0; retired = 0. Asserting rst mid-run aborts any pending write at that edge.
- State machine, two states: RUN, HALT.
  - RUN, stat_w = AOK: perform writes; retired += 1; stay in RUN.
  - RUN, stat_w = BUB: no write, no count, prog_stat stays AOK.
  - RUN, stat_w in {HLT, ADR, INS}:
    - no register write;
    - retired += 1 for HLT only (ADR/INS do not retire);
    - prog_stat <= stat_w; halted <= 1; go to HALT.
  - RUN, stat_w in {5, 6, 7} (illegal): treat as INS (prog_stat <= 4, go to HALT).
  - HALT: all writes suppressed; retired frozen; prog_stat and halted hold. Only rst leaves HALT.
- Write rules (RUN, stat_w = AOK, at the rising edge):
  - dstE_w != 4'hF: reg[dstE_w] <= valE_w.
  - dstM_w != 4'hF: reg[dstM_w] <= valM_w.
  - dstE_w == dstM_w != 4'hF: the valM write wins (popq %rsp semantics).
- Reads: combinational. rvalX_d = reg[srcX_d]; srcX_d = 4'hF returns 0.
  - Without the optional feature, a read of a register being written in the same cycle returns the old value. Decode forwarding covers this case.
- Counter: wraps from 2^CNT_W-1 to 0 silently; no saturation.
- Latency: register update visible on the read ports one cycle after the W inputs are presented, through the clk edge.
- icode_w is not used for write gating; a bubble is identified by stat_w = BUB only.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: the read ports are write-through.
  - If srcX_d matches a valid write address this cycle (RUN, stat_w = AOK), rvalX_d returns the incoming value.
  - Uses valM_w priority when both dstE_w and dstM_w match.
  - Adds a combinational path from valE_w/valM_w to rvalA_d/rvalB_d.
- Not defined: reads return only stored register contents, as described in Behaviour.

Test Plan:
- Reset check: assert rst for 2 cycles, then read all srcA_d 0..14. Required: all 0; prog_stat = 1; halted = 0; retired = 0. Read srcA_d = F: 0.
- Dual write: stat_w = 1, dstE_w = 3, valE_w = 0x1111, dstM_w = 5, valM_w = 0x2222. Required: next cycle reg3 = 0x1111, reg5 = 0x2222, retired = 1. With dstE_w = dstM_w = 4, valE_w = 0xAA, valM_w = 0xBB: reg4 = 0xBB.
- Bubble and RNONE: stat_w = 0 with dstE_w = 2 → reg2 unchanged, retired unchanged. stat_w = 1 with both dst = F → no register change, retired += 1.
- Halt: stat_w = 2 with dstE_w = 6, valE_w = 0x77 → reg6 unchanged, prog_stat = 2, halted = 1, retired += 1. Then stat_w = 1 writes to reg1 → ignored, retired frozen.
- Error stat: stat_w = 3 → prog_stat = 3, no retire increment. Separately, stat_w = 6 → prog_stat = 4. Assert rst asynchronously between clock edges while halted → immediate return to AOK/RUN with all registers 0.
- Bypass (WB_BYPASS_EN defined): stat_w = 1, dstE_w = 7, valE_w = 0x55, srcA_d = 7 in the same cycle → rvalA_d = 0x55 before the edge. Without the macro → rvalA_d = old reg7 value.
